// File: rtl/spi_flash_ctrl.sv
// Memory-mapped read controller for a single-bit SPI flash (mode 0, READ 0x03).
// Define FLASH_FAST_READ_EN to issue FAST_READ 0x0B with 8 dummy clocks instead.
module spi_flash_ctrl #(
  parameter int unsigned DIVIDER = 1,
  parameter int unsigned CS_HIGH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_in,
  input  logic [23:0] address_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_io0_en,
  output logic        flash_io0_out,
  input  logic        flash_io1_in
);

  // state | meaning
  // IDLE  | csn high, waiting for sel_in
  // START | csn low, command/address loaded, first MOSI bit presented
  // SHIFT | clocking command, address, (dummy,) data bits MSB first
  // DONE  | ready_out pulse with the assembled word
  // DESEL | csn held high for CS_HIGH cycles

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0]  CMD   = 8'h0B;
  localparam int unsigned NBITS = 72;
`else
  localparam logic [7:0]  CMD   = 8'h03;
  localparam int unsigned NBITS = 64;
`endif
  localparam int unsigned CMAX     = (DIVIDER > CS_HIGH) ? DIVIDER : CS_HIGH;
  localparam int unsigned CW       = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIVIDER);
  localparam logic [CW-1:0] CSH_LD = CW'(CS_HIGH);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [6:0] LAST_BIT  = 7'(NBITS - 1);
  localparam logic [6:0] DATA_BIT  = 7'(NBITS - 32);

  typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, DESEL} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [6:0]    bit_q;
  logic [31:0]   tx_q;
  logic [31:0]   rx_q;
  logic [31:0]   rdata_q;
  logic          fclk_q, csn_q, io0_en_q, io0_q, ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DESEL;
      cnt_q    <= CSH_LD;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      fclk_q   <= 1'b0;
      csn_q    <= 1'b1;
      io0_en_q <= 1'b0;
      io0_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_in) begin
            state_q  <= START;
            tx_q     <= {CMD, address_in};
            io0_q    <= CMD[7];
            io0_en_q <= 1'b1;
            csn_q    <= 1'b0;
            fclk_q   <= 1'b0;
            bit_q    <= '0;
            cnt_q    <= DIV_LD;
          end
        end
        START, SHIFT: begin
          if (!sel_in) begin
            state_q  <= DESEL;
            cnt_q    <= CSH_LD;
            csn_q    <= 1'b1;
            fclk_q   <= 1'b0;
            io0_en_q <= 1'b0;
            io0_q    <= 1'b0;
          end else if (state_q == START) begin
            state_q <= SHIFT;
          end else if (cnt_q != ONE) begin
            cnt_q <= cnt_q - ONE;
          end else begin
            cnt_q  <= DIV_LD;
            fclk_q <= ~fclk_q;
            if (!fclk_q) begin
              if (bit_q >= DATA_BIT) rx_q <= {rx_q[30:0], flash_io1_in};
            end else if (bit_q == LAST_BIT) begin
              state_q  <= DONE;
              ready_q  <= 1'b1;
              rdata_q  <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
              io0_en_q <= 1'b0;
              io0_q    <= 1'b0;
            end else begin
              // tx zero-fills, so MOSI naturally idles low after the address
              bit_q    <= bit_q + 7'd1;
              tx_q     <= {tx_q[30:0], 1'b0};
              io0_q    <= tx_q[30];
              io0_en_q <= (bit_q < 7'd31);
            end
          end
        end
        DONE: begin
          state_q <= DESEL;
          cnt_q   <= CSH_LD;
          ready_q <= 1'b0;
          rdata_q <= '0;
          csn_q   <= 1'b1;
        end
        DESEL: begin
          if (cnt_q == ONE) state_q <= IDLE;
          else              cnt_q   <= cnt_q - ONE;
        end
        default: begin
          state_q <= DESEL;
          cnt_q   <= CSH_LD;
        end
      endcase
    end
  end

  assign read_value_out = rdata_q;
  assign ready_out      = ready_q;
  assign flash_clk      = fclk_q;
  assign flash_csn      = csn_q;
  assign flash_io0_en   = io0_en_q;
  assign flash_io0_out  = io0_q;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Scoreboard bench for spi_flash_ctrl: two instances (DIVIDER=1 and 3) against a behavioural flash.
module tb_spi_flash_ctrl;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int NB = 72;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int NB = 64;
`endif
  localparam int DSTART  = NB - 32;
  localparam int CS_HIGH = 4;

  typedef struct { int inst; logic [31:0] data; int at; } exp_t;
  typedef struct { int inst; logic [31:0] v; } mo_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel   [2];
  logic [23:0] addr  [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        fclk  [2];
  logic        csn   [2];
  logic        io0_en[2];
  logic        io0   [2];
  logic        io1   [2];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  exp_t exp_q[$];
  mo_t  mo_q[$];

  spi_flash_ctrl #(.DIVIDER(1), .CS_HIGH(CS_HIGH)) u_dut0 (
    .clk(clk), .reset(reset), .sel_in(sel[0]), .address_in(addr[0]),
    .read_value_out(rdata[0]), .ready_out(rdy[0]), .flash_clk(fclk[0]),
    .flash_csn(csn[0]), .flash_io0_en(io0_en[0]), .flash_io0_out(io0[0]),
    .flash_io1_in(io1[0]));

  spi_flash_ctrl #(.DIVIDER(3), .CS_HIGH(CS_HIGH)) u_dut1 (
    .clk(clk), .reset(reset), .sel_in(sel[1]), .address_in(addr[1]),
    .read_value_out(rdata[1]), .ready_out(rdy[1]), .flash_clk(fclk[1]),
    .flash_csn(csn[1]), .flash_io0_en(io0_en[1]), .flash_io0_out(io0[1]),
    .flash_io1_in(io1[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int lat(input int i);
    return 2 + 2 * NB * div_of(i);
  endfunction

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      24'h000104: return 8'h55;
      24'h000105: return 8'h66;
      24'h000106: return 8'h77;
      24'h000107: return 8'h88;
      24'h00FFFE: return 8'hAA;
      24'h00FFFF: return 8'hBB;
      24'h010000: return 8'hCC;
      24'h010001: return 8'hDD;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural flash: MOSI capture, MISO drive, SPI timing checks.
  int          bitn[2]      = '{0, 0};
  int          lowcnt[2]    = '{0, 0};
  int          hi_len[2]    = '{0, 0};
  int          hi_run[2]    = '{0, 0};
  int          last_hi[2]   = '{0, 0};
  int          n_rise[2]    = '{0, 0};
  int          last_rise[2] = '{0, 0};
  int          phase_bad[2] = '{0, 0};
  int          en_bad       = 0;
  int          nz_bad       = 0;
  logic        fprev[2]     = '{1'b0, 1'b0};
  logic        cur_bit[2]   = '{1'b0, 1'b0};
  logic [31:0] mosi_sh[2]   = '{32'h0, 32'h0};
  logic [23:0] faddr[2]     = '{24'h0, 24'h0};

  always @(negedge clk) begin
    int idx;
    logic [7:0] b;
    mo_t m;
    for (int i = 0; i < 2; i++) begin
      if (rdy[i] !== 1'b1 && rdata[i] !== 32'h0) nz_bad++;
      if (csn[i] !== 1'b0) begin
        bitn[i]    = 0;
        n_rise[i]  = 0;
        lowcnt[i]  = 0;
        cur_bit[i] = 1'b0;
        hi_run[i]++;
      end else begin
        if (hi_run[i] != 0) begin
          last_hi[i] = hi_run[i];
          hi_run[i]  = 0;
        end
        if (fclk[i] === 1'b1 && fprev[i] === 1'b0) begin
          if (n_rise[i] > 0 && cyc - last_rise[i] != 2 * div_of(i)) phase_bad[i]++;
          n_rise[i]++;
          last_rise[i] = cyc;
          hi_len[i]    = 1;
          if (bitn[i] < 32) begin
            if (io0_en[i] !== 1'b1) en_bad++;
            mosi_sh[i] = {mosi_sh[i][30:0], io0[i]};
          end else if (io0_en[i] !== 1'b0 || io0[i] !== 1'b0) begin
            en_bad++;
          end
          bitn[i]++;
          if (bitn[i] == 32) begin
            faddr[i] = mosi_sh[i][23:0];
            if (mo_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL mosi_unexpected inst %0d: got 0x%08h, expected no transaction", i, mosi_sh[i]);
            end else begin
              m = mo_q.pop_front();
              chk("mosi_inst", 64'(i), 64'(m.inst));
              chk("mosi_cmd_addr", 64'(mosi_sh[i]), 64'(m.v));
            end
          end
        end else if (fclk[i] === 1'b1) begin
          hi_len[i]++;
        end else if (fprev[i] === 1'b1) begin
          if (hi_len[i] != div_of(i)) phase_bad[i]++;
          lowcnt[i] = 1;
          if (bitn[i] >= DSTART) begin
            idx        = bitn[i] - DSTART;
            b          = mem_byte(faddr[i] + 24'(idx / 8));
            cur_bit[i] = b[7 - (idx % 8)];
          end
        end else begin
          lowcnt[i]++;
        end
      end
      fprev[i] = fclk[i];
      // MISO is valid only in the last low cycle, so early or late sampling reads junk
      io1[i] = (csn[i] === 1'b0 && fclk[i] === 1'b0 && lowcnt[i] == div_of(i)) ? cur_bit[i] : ~cur_bit[i];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rdy[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ready_unexpected inst %0d: got data 0x%08h at cycle %0d, expected no ready", i, rdata[i], cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ready_inst", 64'(i), 64'(e.inst));
          chk("ready_data", 64'(rdata[i]), 64'(e.data));
          chk("ready_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_exp(input int i, input logic [31:0] d, input int at);
    exp_t e;
    e.inst = i; e.data = d; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic push_mosi(input int i, input logic [23:0] a);
    mo_t m;
    m.inst = i; m.v = {CMD, a};
    mo_q.push_back(m);
  endtask

  task automatic start_req(input int i, input logic [23:0] a, output int t);
    sel[i]  = 1'b1;
    addr[i] = a;
    t       = cyc;
  endtask

  task automatic read_word(input int i, input logic [23:0] a, input logic [31:0] d);
    int t;
    start_req(i, a, t);
    push_mosi(i, a);
    push_exp(i, d, t + lat(i));
    wait_until(t + lat(i));
    sel[i] = 1'b0;
    idle(10);
  endtask

  initial begin
    int t, t2, r0;
    sel[0] = 1'b0; sel[1] = 1'b0;
    addr[0] = 24'h0; addr[1] = 24'h0;
    reset = 1'b1;
    idle(3);
    chk("rst_csn", 64'(csn[0]), 64'd1);
    chk("rst_fclk", 64'(fclk[0]), 64'd0);
    chk("rst_io0_en", 64'(io0_en[0]), 64'd0);
    chk("rst_io0", 64'(io0[0]), 64'd0);
    chk("rst_ready", 64'(rdy[0]), 64'd0);
    chk("rst_rdata", 64'(rdata[0]), 64'd0);
    reset = 1'b0;
    idle(8);

    read_word(0, 24'h000100, 32'h44332211);

    // back-to-back with sel_in held through ready
    start_req(0, 24'h000100, t);
    push_mosi(0, 24'h000100);
    push_exp(0, 32'h44332211, t + lat(0));
    wait_until(t + lat(0));
    addr[0] = 24'h000104;
    t2 = t + lat(0) + CS_HIGH + 1;
    push_mosi(0, 24'h000104);
    push_exp(0, 32'h88776655, t2 + lat(0));
    wait_until(t2 + lat(0));
    chk("b2b_csn_high_cycles", 64'(last_hi[0]), 64'(CS_HIGH + 1));
    sel[0] = 1'b0;
    idle(10);

    // abort by dropping sel_in at the start of bit 20
    start_req(0, 24'h000100, t);
    wait_until(t + 2 + 2 * 20 * div_of(0));
    chk("abort_csn_before", 64'(csn[0]), 64'd0);
    sel[0] = 1'b0;
    idle(1);
    chk("abort_csn", 64'(csn[0]), 64'd1);
    chk("abort_fclk", 64'(fclk[0]), 64'd0);
    chk("abort_io0_en", 64'(io0_en[0]), 64'd0);
    idle(10);
    read_word(0, 24'h000104, 32'h88776655);

    // reset at the start of bit 40, request kept pending across it
    start_req(0, 24'h000100, t);
    push_mosi(0, 24'h000100);
    wait_until(t + 2 + 2 * 40 * div_of(0));
    reset = 1'b1;
    idle(1);
    chk("midrst_csn", 64'(csn[0]), 64'd1);
    chk("midrst_fclk", 64'(fclk[0]), 64'd0);
    chk("midrst_io0_en", 64'(io0_en[0]), 64'd0);
    chk("midrst_ready", 64'(rdy[0]), 64'd0);
    chk("midrst_rdata", 64'(rdata[0]), 64'd0);
    reset = 1'b0;
    r0 = cyc;
    push_mosi(0, 24'h000100);
    push_exp(0, 32'h44332211, r0 + CS_HIGH + lat(0));
    wait_until(r0 + CS_HIGH + lat(0));
    sel[0] = 1'b0;
    idle(10);

    read_word(0, 24'h00FFFE, 32'hDDCCBBAA);
    read_word(1, 24'h000100, 32'h44332211);
    read_word(1, 24'h00FFFE, 32'hDDCCBBAA);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("mosi_drained", 64'(mo_q.size()), 64'd0);
    chk("rdata_zero_when_idle", 64'(nz_bad), 64'd0);
    chk("io0_enable_windows", 64'(en_bad), 64'd0);
    chk("fclk_phases_div1", 64'(phase_bad[0]), 64'd0);
    chk("fclk_phases_div3", 64'(phase_bad[1]), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
